// File: rtl/game_seq.sv
// Per-frame game sequencer: button conditioning, command arbitration, game FSM, score/lives/LEDs.
// Build option: define GAME_SEQ_AUTOFIRE_EN for repeating fire while both buttons are held.
module game_seq #(
  parameter int LIVES      = 3,
  parameter int DEB_FRAMES = 3,
  parameter int FIRE_CD    = 15,
  parameter int HIT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       ship_hit,
  input  logic       enemy_kill,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       field_rst,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] leds
);
  localparam int NUM_BTN = 2;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_HIT  = 2'b10;
  localparam logic [1:0] S_OVER = 2'b11;
  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

  logic [NUM_BTN-1:0]       raw, sync1, sync2, deb, deb_n;
  logic [NUM_BTN-1:0][3:0]  deb_cnt;
  logic                     both, both_prev, both_rise, fire_ok;
  logic [7:0]               cd, cd_n, hit_cnt, hit_n;
  logic [4:0]               fcnt;
  logic                     pat, pat_n;
  logic [1:0]               state_n, lives_n;
  logic [7:0]               score_n, leds_n;
  logic                     ml_n, mr_n, fire_n, frst_n;

  assign raw = {btn_right, btn_left};

  // Debounced level as it will be after this tick, so decisions see the fresh value.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      deb_n[i] = deb[i];
      if (frame_tick && (sync2[i] != deb[i]) && (deb_cnt[i] == DEB_LAST))
        deb_n[i] = sync2[i];
    end
  end

  assign both      = &deb_n;
  assign both_rise = both & ~both_prev;
`ifdef GAME_SEQ_AUTOFIRE_EN
  assign fire_ok   = both && (cd == 8'd0);
`else
  assign fire_ok   = both_rise && (cd == 8'd0);
`endif

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    cd_n    = cd;
    hit_n   = hit_cnt;
    ml_n    = 1'b0;
    mr_n    = 1'b0;
    fire_n  = 1'b0;
    frst_n  = 1'b0;
    case (state)
      S_IDLE: if (frame_tick && both_rise) begin
        state_n = S_PLAY;
        score_n = 8'd0;
        lives_n = 2'(LIVES);
        cd_n    = 8'd0;
        frst_n  = 1'b1;
      end
      S_PLAY: begin
        if (enemy_kill && score != 8'hFF) score_n = score + 8'd1;
        // A hit pre-empts any command decision on the same tick.
        if (ship_hit) begin
          lives_n = lives - 2'd1;
          if (lives == 2'd1) state_n = S_OVER;
          else begin
            state_n = S_HIT;
            hit_n   = 8'(HIT_FRAMES);
          end
        end else if (frame_tick) begin
          ml_n = deb_n[0] & ~deb_n[1];
          mr_n = deb_n[1] & ~deb_n[0];
          if (fire_ok) begin
            fire_n = 1'b1;
            cd_n   = 8'(FIRE_CD);
          end else if (cd != 8'd0) cd_n = cd - 8'd1;
        end
      end
      S_HIT: if (frame_tick) begin
        hit_n = hit_cnt - 8'd1;
        if (hit_cnt == 8'd1) begin
          state_n = S_PLAY;
          frst_n  = 1'b1;
          cd_n    = 8'd0;
        end
      end
      default: if (frame_tick && both_rise) state_n = S_IDLE;
    endcase
  end

  // Attract pattern flips once every 32 frames.
  always_comb begin
    pat_n = pat;
    if (frame_tick && fcnt == 5'd31) pat_n = ~pat;
    case (state_n)
      S_IDLE:  leds_n = pat_n ? 8'h55 : 8'hAA;
      S_HIT:   leds_n = 8'hFF;
      default: leds_n = score_n;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_cnt    <= '0;
      both_prev  <= 1'b0;
      fcnt       <= 5'd0;
      pat        <= 1'b0;
      cd         <= 8'd0;
      hit_cnt    <= 8'd0;
      state      <= S_IDLE;
      score      <= 8'd0;
      lives      <= 2'(LIVES);
      leds       <= 8'hAA;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      field_rst  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_n;
      if (frame_tick) begin
        both_prev <= both;
        fcnt      <= fcnt + 5'd1;
        for (int i = 0; i < NUM_BTN; i++)
          deb_cnt[i] <= ((sync2[i] == deb[i]) || (deb_cnt[i] == DEB_LAST)) ? 4'd0 : deb_cnt[i] + 4'd1;
      end
      pat        <= pat_n;
      cd         <= cd_n;
      hit_cnt    <= hit_n;
      state      <= state_n;
      score      <= score_n;
      lives      <= lives_n;
      leds       <= leds_n;
      move_left  <= ml_n;
      move_right <= mr_n;
      fire       <= fire_n;
      field_rst  <= frst_n;
    end
  end
endmodule

// File: tb/tb_game_seq.sv
// Bench for game_seq: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a frame-level reference model.
module tb_game_seq;
  localparam int LIVES = 3, DEB = 3, FIRE_CD = 15, HIT_FRAMES = 60;

  logic clk = 0, reset = 0, frame_tick = 0, btn_left = 0, btn_right = 0;
  logic ship_hit = 0, enemy_kill = 0;
  logic move_left, move_right, fire, field_rst;
  logic [1:0] state, lives;
  logic [7:0] score, leds;

  int vectors = 0, miscompares = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  game_seq dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .ship_hit(ship_hit), .enemy_kill(enemy_kill),
    .move_left(move_left), .move_right(move_right), .fire(fire), .field_rst(field_rst),
    .state(state), .score(score), .lives(lives), .leds(leds)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: game state as plain integers.
  int m_state, m_score, m_lives, m_cd, m_hit_left, m_ntick, m_prev_both;
  int m_ml, m_mr, m_fire, m_frst;
  int m_lvl[2], m_run[2], m_syn1[2], m_syn2[2];

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = LIVES; m_cd = 0; m_hit_left = 0;
    m_ntick = 0; m_prev_both = 0; m_ml = 0; m_mr = 0; m_fire = 0; m_frst = 0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_syn1[i] = 0; m_syn2[i] = 0;
    end
  endtask

  task automatic model_step();
    int samp[2];
    int both, rise, fire_ok;
    samp[0] = m_syn2[0]; samp[1] = m_syn2[1];
    m_ml = 0; m_mr = 0; m_fire = 0; m_frst = 0;
    if (frame_tick) begin
      for (int i = 0; i < 2; i++) begin
        if (samp[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin m_lvl[i] = samp[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
    end
    both = m_lvl[0] & m_lvl[1];
    rise = (both != 0 && m_prev_both == 0) ? 1 : 0;
`ifdef GAME_SEQ_AUTOFIRE_EN
    fire_ok = (both != 0 && m_cd == 0) ? 1 : 0;
`else
    fire_ok = (rise != 0 && m_cd == 0) ? 1 : 0;
`endif
    case (m_state)
      0: if (frame_tick && rise != 0) begin
        m_state = 1; m_score = 0; m_lives = LIVES; m_cd = 0; m_frst = 1;
      end
      1: begin
        if (enemy_kill) m_score = (m_score < 255) ? m_score + 1 : 255;
        if (ship_hit) begin
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_hit_left = HIT_FRAMES; end
        end else if (frame_tick) begin
          m_ml = (m_lvl[0] == 1 && m_lvl[1] == 0) ? 1 : 0;
          m_mr = (m_lvl[1] == 1 && m_lvl[0] == 0) ? 1 : 0;
          if (fire_ok != 0) begin m_fire = 1; m_cd = FIRE_CD; end
          else if (m_cd > 0) m_cd--;
        end
      end
      2: if (frame_tick) begin
        m_hit_left--;
        if (m_hit_left == 0) begin m_state = 1; m_frst = 1; m_cd = 0; end
      end
      default: if (frame_tick && rise != 0) m_state = 0;
    endcase
    if (frame_tick) begin m_prev_both = both; m_ntick++; end
    m_syn2[0] = m_syn1[0]; m_syn2[1] = m_syn1[1];
    m_syn1[0] = btn_left;  m_syn1[1] = btn_right;
  endtask

  function automatic int exp_leds();
    if (m_state == 0) return ((m_ntick / 32) % 2 == 1) ? 8'h55 : 8'hAA;
    if (m_state == 2) return 8'hFF;
    return m_score;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("state", state, m_state);
      chk("score", score, m_score);
      chk("lives", lives, m_lives);
      chk("leds", leds, exp_leds());
      chk("move_left", move_left, m_ml);
      chk("move_right", move_right, m_mr);
      chk("fire", fire, m_fire);
      chk("field_rst", field_rst, m_frst);
    end
  end

  // Snapshot of outputs in the cycle after each frame tick.
  logic [1:0] s_state, s_lives;
  logic [7:0] s_score;
  logic s_ml, s_mr, s_fire, s_frst;

  task automatic drive(input bit t, input bit l, input bit r, input bit h, input bit k);
    @(posedge clk); #1;
    frame_tick = t; btn_left = l; btn_right = r; ship_hit = h; enemy_kill = k;
  endtask

  task automatic frame(input bit l, input bit r);
    drive(1, l, r, 0, 0);
    drive(0, l, r, 0, 0);
    @(negedge clk);
    s_state = state; s_lives = lives; s_score = score;
    s_ml = move_left; s_mr = move_right; s_fire = fire; s_frst = field_rst;
    drive(0, l, r, 0, 0);
    drive(0, l, r, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_leds"}, leds, 8'hAA);
    chk({tag, "_pulses"}, {move_left, move_right, fire, field_rst}, 0);
  endtask

  initial begin
    bit l, r;
    int e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1;
    chk_en = 1;

    // Start: both held from frame 0 -> PLAY after the third sample.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      frame(1, 1);
      chk("start_state", s_state, (k == 2) ? 1 : 0);
      chk("start_frst", s_frst, (k == 2) ? 1 : 0);
    end
    chk("start_score", s_score, 0);
    chk("start_lives", s_lives, 3);
    repeat (20) frame(0, 0);

    // Left held: one move_left per frame once debounced.
    for (int k = 0; k < 13; k++) begin
      frame(1, 0);
      chk("left_ml", s_ml, (k >= 3) ? 1 : 0);
      chk("left_mr", s_mr, 0);
      chk("left_fire", s_fire, 0);
    end
    repeat (4) frame(0, 0);

    // Both held 40 frames after debounce.
    for (int k = 0; k < 43; k++) begin
      frame(1, 1);
`ifdef GAME_SEQ_AUTOFIRE_EN
      e = (k >= 3 && (k - 3) % 16 == 0) ? 1 : 0;
`else
      e = (k == 3) ? 1 : 0;
`endif
      chk("both_fire", s_fire, e);
      chk("both_ml", s_ml, 0);
    end
    repeat (4) frame(0, 0);
    for (int k = 0; k < 4; k++) begin
      frame(1, 1);
`ifndef GAME_SEQ_AUTOFIRE_EN
      chk("repress_fire", s_fire, (k == 3) ? 1 : 0);
`endif
    end
    repeat (20) frame(0, 0);

    // Ship hit with lives=3, left held through HIT.
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("hit_state", state, 2);
    chk("hit_lives", lives, 2);
    chk("hit_leds", leds, 8'hFF);
    for (int k = 0; k < 60; k++) begin
      frame(1, 0);
      chk("hit_wait_state", s_state, (k == 59) ? 1 : 0 + ((k == 59) ? 0 : 2));
      chk("hit_wait_frst", s_frst, (k == 59) ? 1 : 0);
      chk("hit_wait_ml", s_ml, 0);
    end
    repeat (4) frame(0, 0);

    // Down to one life, score to 254, then hit+kill together.
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    repeat (60) frame(0, 0);
    chk("hit2_state", s_state, 1);
    chk("hit2_lives", s_lives, 1);
    repeat (254) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("over_score", score, 255);
    chk("over_lives", lives, 0);
    chk("over_state", state, 3);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("over_sat", score, 255);
    for (int k = 0; k < 4; k++) begin
      frame(1, 1);
      chk("over_exit", s_state, (k == 3) ? 0 : 3);
    end

    // Back into PLAY, score 7, then an asynchronous reset pulse between edges.
    repeat (4) frame(0, 0);
    for (int k = 0; k < 4; k++) begin
      frame(1, 1);
      chk("replay_state", s_state, (k == 3) ? 1 : 0);
    end
    repeat (4) frame(0, 0);
    repeat (7) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_score", score, 7);
    #2 reset = 0;
    #1 chk_reset_vals("async_rst");
    #1 reset = 1;

    // Random traffic.
    l = 0; r = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) l = ~l;
      if ($urandom_range(0, 15) == 0) r = ~r;
      drive(($urandom_range(0, 2) == 0), l, r, ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 0;
        #1 reset = 1;
      end
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
